mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 output channel between four requesters.
- Registers the 2-bit mux select and a one-hot grant. Passes the granted requester's data to a single downstream port through a valid/ready handshake.
- Bounds each requester's tenure to MAX_HOLD transfers while others wait, so no requester starves.
- Sits directly in front of the existing 4:1 mux datapath and generates its select; the mux may be instantiated internally.

---
 rtl/mux_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter + 4:1 mux sharing one output channel among four requesters.
// Latency: req-to-grant 1 cycle; out/out_valid combinational from registered select.
// Backpressure: ready=0 freezes the tenure indefinitely; tenure capped at MAX_HOLD transfers only under contention.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req[3:0]         per-requester valid; in0..in3 are the matching data words
//   ready            downstream accepts out this cycle
//   select[1:0]      registered index of current/last grantee (drives the mux)
//   grant[3:0]       registered one-hot grant, zero when idle
//   out, out_valid   muxed data and its valid toward downstream
module mux_rr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_HOLD   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            req,
   input  logic [DATA_WIDTH-1:0] in0,
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic [DATA_WIDTH-1:0] in2,
   input  logic [DATA_WIDTH-1:0] in3,
   input  logic                  ready,
   output logic [1:0]            select,
   output logic [3:0]            grant,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  out_valid
);

   localparam int HW = $clog2(MAX_HOLD + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    grant_q, grant_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [HW-1:0] hold_q, hold_d;

   logic          xfer;
   logic          others;
   logic          limit;
   logic          release_g;
   logic [1:0]    search_ptr;
   logic [2:0]    pick;      // {found, index}

   // First requester at or after p, wrapping mod 4. Iterating from the far end
   // lets the nearest hit overwrite earlier ones.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign out_valid = (state_q == ST_GRANT) && req[sel_q];
   assign xfer      = out_valid && ready;
   assign others    = |(req & ~grant_q);
   assign limit     = xfer && (hold_q == HW'(MAX_HOLD - 1));
   assign release_g = !req[sel_q] || (limit && others);

   // On release the search restarts just past the grantee, so the grantee's own
   // request (if still high) is the last candidate considered.
   assign search_ptr = (state_q == ST_GRANT) ? (sel_q + 2'd1) : ptr_q;
   assign pick       = rr_pick(req, search_ptr);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (pick[2]) begin
               state_d = ST_GRANT;
               sel_d   = pick[1:0];
               grant_d = 4'b0001 << pick[1:0];
               hold_d  = '0;
            end
         end
         ST_GRANT: begin
            if (release_g) begin
               ptr_d  = sel_q + 2'd1;
               hold_d = '0;
               if (pick[2]) begin
                  sel_d   = pick[1:0];
                  grant_d = 4'b0001 << pick[1:0];
               end else begin
                  state_d = ST_IDLE;
                  grant_d = 4'b0000;
               end
            end else if (limit) begin
               // Sole requester: restart the tenure count rather than preempt.
               hold_d = '0;
            end else if (xfer) begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'd0;
         grant_q <= 4'b0000;
         ptr_q   <= 2'd0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   assign select = sel_q;
   assign grant  = grant_q;

   always_comb begin
      case (sel_q)
         2'd0:    out = in0;
         2'd1:    out = in1;
         2'd2:    out = in2;
         default: out = in3;
      endcase
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios followed by random traffic,
// each cycle compared against a transfer-counting reference model.
module tb_mux_rr_arbiter;

   localparam int DW       = 8;
   localparam int MAX_HOLD = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    req;
   logic [DW-1:0] in0, in1, in2, in3;
   logic          ready;
   logic [1:0]    select;
   logic [3:0]    grant;
   logic [DW-1:0] out;
   logic          out_valid;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: who owns the channel, how many words it has moved in
   // this tenure, and where the next round-robin scan begins.
   int m_owner;   // -1 when nobody holds the channel
   int m_last;
   int m_ptr;
   int m_cnt;

   mux_rr_arbiter #(.DATA_WIDTH(DW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .ready(ready), .select(select), .grant(grant),
      .out(out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic int pick(input logic [3:0] r, input int start);
      for (int k = 0; k < 4; k++)
         if (r[(start + k) % 4]) return (start + k) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 0;
      m_ptr   = 0;
      m_cnt   = 0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic rdy);
      int  w;
      bit  served, others, done;
      logic [3:0] mine;
      if (m_owner < 0) begin
         w = pick(r, m_ptr);
         if (w >= 0) begin
            m_owner = w; m_last = w; m_cnt = 0;
         end
      end else begin
         mine   = 4'b0001 << m_owner;
         served = r[m_owner] && rdy;
         others = (r & ~mine) != 4'b0000;
         done   = served && (m_cnt + 1 == MAX_HOLD);
         if (!r[m_owner] || (done && others)) begin
            m_ptr = (m_owner + 1) % 4;
            w = pick(r, m_ptr);
            if (w >= 0) begin
               m_owner = w; m_last = w; m_cnt = 0;
            end else begin
               m_owner = -1;
            end
         end else if (served) begin
            m_cnt = done ? 0 : m_cnt + 1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0]    eg;
      logic [DW-1:0] eo;
      logic          ev;
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      ev = (m_owner >= 0) && req[m_owner];
      case (m_last)
         0:       eo = in0;
         1:       eo = in1;
         2:       eo = in2;
         default: eo = in3;
      endcase
      chk({tag, "_grant"},  32'(grant),     32'(eg));
      chk({tag, "_select"}, 32'(select),    32'(m_last));
      chk({tag, "_valid"},  32'(out_valid), 32'(ev));
      chk({tag, "_out"},    32'(out),       32'(eo));
   endtask

   // One clock: drive at negedge, compare mid-cycle, advance model at posedge.
   task automatic cycle(input string tag, input logic [3:0] r, input logic rdy);
      @(negedge clk);
      rst_n = 1'b1;
      req   = r;
      ready = rdy;
      in0   = DW'($urandom);
      in1   = DW'($urandom);
      in2   = DW'($urandom);
      in3   = DW'($urandom);
      #1;
      check_outputs(tag);
      @(posedge clk);
      model_edge(r, rdy);
   endtask

   // Reset asserted between edges; outputs must clear with no clock edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs(tag);
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      req   = 4'b1111;
      ready = 1'b1;
      in0 = 8'hA0; in1 = 8'hA1; in2 = 8'hA2; in3 = 8'hA3;
      #1;
      check_outputs("reset");
      chk("reset_out_a0", 32'(out), 32'h0000_00A0);

      // Reset release, then full contention with one-edge grant latency.
      cycle("contend", 4'b1111, 1'b1);
      #1;
      chk("first_grant", 32'(grant), 32'h1);
      chk("first_valid", 32'(out_valid), 32'h1);
      for (int i = 0; i < 17; i++) cycle("contend", 4'b1111, 1'b1);

      // Sole requester never preempted.
      for (int i = 0; i < 22; i++) cycle("single", 4'b0100, 1'b1);
      #1;
      chk("single_grant", 32'(grant), 32'h4);

      // Backpressure: reset to a known pointer, then hold ready low.
      async_reset("bp_rst");
      for (int i = 0; i < 10; i++) cycle("bp_stall", 4'b0011, 1'b0);
      #1;
      chk("bp_hold_grant", 32'(grant), 32'h1);
      for (int i = 0; i < 4; i++) cycle("bp_go", 4'b0011, 1'b1);
      #1;
      chk("bp_switch_grant", 32'(grant), 32'h2);

      // Early drop: requester 1 leaves after two transfers; 2 is skipped.
      async_reset("drop_rst");
      cycle("drop_pre", 4'b0010, 1'b1);
      cycle("drop_xfer", 4'b1010, 1'b1);
      cycle("drop_xfer", 4'b1010, 1'b1);
      cycle("drop_edge", 4'b1000, 1'b1);
      #1;
      chk("drop_grant", 32'(grant), 32'h8);
      chk("drop_select", 32'(select), 32'h3);
      cycle("drop_post", 4'b1000, 1'b1);

      // Async reset in the middle of a grant on requester 1.
      async_reset("mid_rst0");
      cycle("mid_pre", 4'b0010, 1'b1);
      async_reset("mid_rst");
      chk("mid_rst_grant", 32'(grant), 32'h0);
      cycle("mid_rel", 4'b0010, 1'b1);
      #1;
      chk("mid_rel_grant", 32'(grant), 32'h2);

      // Random traffic with occasional async resets.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] r;
         logic       rdy;
         r   = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
         cycle("rnd", r, rdy);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
